// File: rtl/mem_access_unit_if.sv
// Data-cache request/response bundle between the memory-access unit (master)
// and the data cache (slave).
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  data_read;
    logic                  data_write;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic [3:0]            data_mbe;
    logic [31:0]           data_wdata;
    logic                  data_resp;
    logic [31:0]           data_rdata;

    modport master (
        output data_read, data_write, data_addr, data_mbe, data_wdata,
        input  data_resp, data_rdata
    );

    modport slave (
        input  data_read, data_write, data_addr, data_mbe, data_wdata,
        output data_resp, data_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: issues one data-cache access per op,
// stalls upstream until it completes and extends load data. Option: MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    mem_access_unit_if.master     dbus,
    output logic [31:0]           load_data,
    output logic                  mem_done,
    output logic                  mem_stall,
    output logic                  misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    state_e                state_q, state_d;
    logic                  is_load_q, is_load_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            mbe_q, mbe_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           load_q, load_d;
    logic                  legal_ld, legal_st, accept;

    function automatic logic [3:0] fmt_mbe(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] fmt_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{off, 3'b000} +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    assign legal_ld = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign legal_st = funct3 inside {3'b000, 3'b001, 3'b010};
    assign accept   = valid_in && ((mem_read_in && !mem_write_in && legal_ld) ||
                                   (mem_write_in && !mem_read_in && legal_st));

`ifdef MISALIGN_TRAP_EN
    logic mis_now, mis_q, mis_d;
    assign mis_now = (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) ||
                     (funct3[1:0] == 2'b01 && addr[0]);
`endif

    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        f3_d      = f3_q;
        off_d     = off_q;
        addr_d    = addr_q;
        mbe_d     = mbe_q;
        wdata_d   = wdata_q;
        load_d    = load_q;
        mem_stall = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis_d     = mis_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_stall = 1'b1;
                    is_load_d = mem_read_in;
                    f3_d      = funct3;
                    off_d     = addr[1:0];
                    addr_d    = {addr[ADDR_WIDTH-1:2], 2'b00};
                    mbe_d     = mem_write_in ? fmt_mbe(funct3, addr[1:0]) : 4'b0000;
                    wdata_d   = mem_write_in ? fmt_wdata(funct3, store_data) : 32'h0;
`ifdef MISALIGN_TRAP_EN
                    // A trapped op skips the cache entirely.
                    mis_d     = mis_now;
                    state_d   = mis_now ? DONE : REQ;
`else
                    state_d   = REQ;
`endif
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dbus.data_resp) begin
                    if (is_load_q) load_d = extract(f3_q, off_q, dbus.data_rdata);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            is_load_q <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            addr_q    <= '0;
            mbe_q     <= 4'b0000;
            wdata_q   <= 32'h0;
            load_q    <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            addr_q    <= addr_d;
            mbe_q     <= mbe_d;
            wdata_q   <= wdata_d;
            load_q    <= load_d;
`ifdef MISALIGN_TRAP_EN
            mis_q     <= mis_d;
`endif
        end
    end

    // Requests derive from the state register so an async reset drops them at once.
    assign dbus.data_read  = (state_q == REQ) && is_load_q;
    assign dbus.data_write = (state_q == REQ) && !is_load_q;
    assign dbus.data_addr  = addr_q;
    assign dbus.data_mbe   = mbe_q;
    assign dbus.data_wdata = wdata_q;
    assign load_data       = load_q;
    assign mem_done        = (state_q == DONE);
`ifdef MISALIGN_TRAP_EN
    assign misaligned      = (state_q == DONE) && mis_q;
`else
    assign misaligned      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random ops against an
// arithmetic reference model (honours MISALIGN_TRAP_EN when defined).
module tb_mem_access_unit;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_read_in, mem_write_in;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        mem_done, mem_stall, misaligned;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_ld;

    mem_access_unit_if #(.ADDR_WIDTH(32)) bus ();

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .dbus         (bus.master),
        .load_data    (load_data),
        .mem_done     (mem_done),
        .mem_stall    (mem_stall),
        .misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: access size in bytes and lane offset after truncation.
    function automatic int unsigned sz(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic int unsigned aoff(input logic [2:0] f3, input logic [31:0] a);
        int unsigned o;
        o = a % 4;
        return o - (o % sz(f3));
    endfunction

    function automatic logic [3:0] ref_mbe(input logic [2:0] f3, input logic [31:0] a);
        int unsigned m;
        m = ((1 << sz(f3)) - 1) << aoff(f3, a);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz(f3)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
        logic [63:0] v;
        int unsigned s;
        s = sz(f3);
        v = {32'h0, rdata} >> (8 * aoff(f3, a));
        if (s < 4) begin
            v = v & ((64'd1 << (8 * s)) - 64'd1);
            if (!f3[2] && v[8*s-1]) v = v - (64'd1 << (8 * s));
        end
        return v[31:0];
    endfunction

    // Called at posedge+1 with the DUT idle; leaves at posedge+1 of the next idle cycle.
    task automatic run_op(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input int wt,
                          input logic [31:0] rdata, input bit stray);
        bit legal, mis;
        legal = v && (rd != wr) && (rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 < 3'd3));
        mis   = legal && ((a % sz(f3)) != 0);
        valid_in = v; mem_read_in = rd; mem_write_in = wr;
        funct3 = f3; addr = a; store_data = sd;
        bus.data_resp = stray; bus.data_rdata = $urandom;
        @(negedge clk);
        chk("acc_stall", 32'(mem_stall), 32'(legal));
        chk("acc_req", {30'd0, bus.data_read, bus.data_write}, 32'd0);
        chk("acc_done", 32'(mem_done), 32'd0);
        @(posedge clk); #1;
        bus.data_resp = 1'b0;
        if (!legal) begin
            valid_in = 1'b0;
            @(negedge clk);
            chk("ign_out", {28'd0, mem_stall, mem_done, bus.data_read, bus.data_write}, 32'd0);
            @(posedge clk); #1;
            return;
        end
        if (!(TRAP && mis)) begin
            for (int k = 0; k <= wt; k++) begin
                bus.data_resp  = (k == wt);
                bus.data_rdata = (k == wt) ? rdata : $urandom;
                @(negedge clk);
                chk("req_rw", {30'd0, bus.data_read, bus.data_write}, {30'd0, rd, wr});
                chk("req_addr", bus.data_addr, a & 32'hFFFF_FFFC);
                chk("req_mbe", 32'(bus.data_mbe), wr ? 32'(ref_mbe(f3, a)) : 32'd0);
                if (wr) chk("req_wdata", bus.data_wdata, ref_wdata(f3, sd));
                chk("req_stall_done", {30'd0, mem_stall, mem_done}, 32'd2);
                @(posedge clk); #1;
            end
            bus.data_resp = 1'b0;
            if (rd) model_ld = ref_load(f3, a, rdata);
        end
        @(negedge clk);
        chk("done_flags", {28'd0, mem_done, mem_stall, bus.data_read, bus.data_write}, 32'd8);
        chk("done_mis", 32'(misaligned), 32'(TRAP && mis));
        chk("done_ld", load_data, model_ld);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
        bus.data_resp = 1'b0; bus.data_rdata = 32'd0;
        model_ld = 32'd0;
        #1;
        chk("rst_out", {28'd0, bus.data_read, bus.data_write, mem_done, misaligned}, 32'd0);
        chk("rst_addr", bus.data_addr, 32'd0);
        chk("rst_mbe_wdata", {28'd0, bus.data_mbe} | bus.data_wdata, 32'd0);
        chk("rst_ld", load_data, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(1, 1, 0, 3'b010, 32'h0000_1004, 32'd0, 2, 32'hDEAD_BEEF, 0);
        chk("lw_val", load_data, 32'hDEAD_BEEF);
        run_op(1, 1, 0, 3'b000, 32'h0000_2003, 32'd0, 1, 32'h80FF_0000, 0);
        chk("lb_val", load_data, 32'hFFFF_FF80);
        run_op(1, 1, 0, 3'b100, 32'h0000_2003, 32'd0, 0, 32'h80FF_0000, 0);
        chk("lbu_val", load_data, 32'h0000_0080);
        run_op(1, 1, 0, 3'b101, 32'h0000_2002, 32'd0, 0, 32'h80FF_0000, 0);
        chk("lhu_val", load_data, 32'h0000_80FF);
        run_op(1, 0, 1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 1, 32'd0, 0);
        chk("sb_mbe", 32'(bus.data_mbe), 32'h2);
        chk("sb_wdata", bus.data_wdata, 32'hABAB_ABAB);
        chk("sb_ld_hold", load_data, 32'h0000_80FF);
        run_op(1, 0, 1, 3'b001, 32'h0000_3002, 32'h1234_56AB, 0, 32'd0, 0);
        chk("sh_mbe", 32'(bus.data_mbe), 32'hC);
        chk("sh_wdata", bus.data_wdata, 32'h56AB_56AB);
        run_op(1, 1, 0, 3'b010, 32'h0000_4002, 32'd0, 0, 32'h0BAD_F00D, 0);
        if (!TRAP) chk("mis_addr", bus.data_addr, 32'h0000_4000);
        run_op(1, 1, 1, 3'b010, 32'h0000_5000, 32'd0, 0, 32'd0, 0);
        run_op(1, 1, 0, 3'b011, 32'h0000_5000, 32'd0, 0, 32'd0, 0);

        // Reset during an outstanding read, followed by a late response.
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
        funct3 = 3'b010; addr = 32'h0000_6000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstreq_rd", 32'(bus.data_read), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("rstreq_drop", {30'd0, bus.data_read, mem_done}, 32'd0);
        valid_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.data_resp = 1'b1; bus.data_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("rstreq_late", {30'd0, mem_done, bus.data_read}, 32'd0);
        chk("rstreq_ld", load_data, 32'd0);
        @(posedge clk); #1;
        bus.data_resp = 1'b0;
        @(negedge clk);
        chk("rstreq_idle", {30'd0, mem_done, mem_stall}, 32'd0);
        model_ld = 32'd0;
        @(posedge clk); #1;

        // Back-to-back store then load, stray response in the load's accept cycle.
        run_op(1, 0, 1, 3'b010, 32'h0000_7000, 32'hCAFE_F00D, 0, 32'd0, 0);
        run_op(1, 1, 0, 3'b010, 32'h0000_7004, 32'd0, 0, 32'h7654_3210, 1);
        chk("b2b_ld", load_data, 32'h7654_3210);

        for (int n = 0; n < 60; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            run_op($urandom_range(0, 7) != 0, r <= 4 || r == 9, r >= 5,
                   3'($urandom_range(0, 7)), $urandom, $urandom,
                   int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-access controller for the pipelined RISC-V core.
- Takes the EX/MEM load/store op and drives the data-cache request (read/write, word address, byte enables, lane-replicated store data).
- Holds the request until the cache responds, then sign/zero-extends load data.
- Stalls the pipeline while the access is outstanding and feeds the memory-stage latch downstream.

Parameters:
- ADDR_WIDTH, 32, width of the byte address and the data_addr output.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  EX/MEM holds a valid instruction
- mem_read_in  in  1  instruction is a load
- mem_write_in  in  1  instruction is a store
- funct3  in  3  RV32I load/store width code
- addr  in  ADDR_WIDTH  byte address from the ALU
- store_data  in  32  rs2 value
- data_resp  in  1  cache completion, one-cycle pulse
- data_rdata  in  32  cache read word, valid with data_resp
- data_read  out  1  read request
- data_write  out  1  write request
- data_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
- data_mbe  out  4  write byte enables
- data_wdata  out  32  write data
- load_data  out  32  extended load result
- mem_done  out  1  access complete, one cycle
- mem_stall  out  1  freeze upstream stages
- misaligned  out  1  misaligned-access flag, one cycle

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0: data_read, data_write, data_addr, data_mbe, data_wdata, load_data, mem_done, misaligned. Any outstanding request is dropped immediately. Release is synchronous to the next clk edge.
- Op accepted: valid_in & exactly one of mem_read_in / mem_write_in & legal funct3.
  - Legal load codes: 000, 001, 010, 100, 101. Legal store codes: 000, 001, 010.
  - Illegal combinations (both read and write asserted, or an illegal funct3) are ignored: no request, no stall, no mem_done.
- FSM IDLE -> REQ -> DONE -> IDLE.
  - IDLE: on an accepted op, register the address, mbe, wdata, funct3 and addr[1:0]; go to REQ. mem_stall is asserted combinationally in this cycle.
  - REQ: data_read or data_write is held high with address, mbe and wdata stable; mem_stall = 1. On data_resp, register the extended data_rdata into load_data and go to DONE. data_resp arriving in IDLE or DONE is ignored.
  - DONE: mem_done = 1, mem_stall = 0, requests low. load_data holds until the next load completes. Always returns to IDLE. The pipeline advances at the end of DONE; the next op is seen in IDLE.
- Minimum latency: 3 cycles from acceptance to mem_done (request asserted 1 cycle after acceptance, resp in the same cycle).
- Store formatting:
  - SB: mbe = 4'b0001 << addr[1:0], wdata = {4{store_data[7:0]}}
  - SH: mbe = 4'b0011 << {addr[1],1'b0}, wdata = {2{store_data[15:0]}}
  - SW: mbe = 4'b1111, wdata = store_data
  - Loads: data_mbe = 0.
- Load extraction:
  - LB / LBU: byte lane addr[1:0], sign-/zero-extended.
  - LH / LHU: half lane addr[1], sign-/zero-extended.
  - LW: full word.
- Misaligned: LW/SW with addr[1:0] != 0, or LH/LHU/SH with addr[0] = 1. See the optional feature.
- Reset asserted in REQ: request deasserts asynchronously; no mem_done.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: a misaligned op in IDLE issues no request. Go directly to DONE. misaligned = 1 in that DONE cycle, load_data is left unchanged, mem_stall = 1 only in the IDLE cycle.
- Undefined: misaligned is tied to 0. The access proceeds with the offending low bits truncated (LW/SW use the word; halves use addr[1]).

Test Plan:
- LW addr 0x0000_1004, resp after 2 wait cycles with rdata 0xDEADBEEF -> data_read high 3 cycles, data_addr 0x1004, load_data 0xDEADBEEF, single mem_done, mem_stall high until DONE.
- LB addr 0x2003, rdata 0x80FF_0000 -> load_data 0xFFFF_FF80. LBU at the same address -> 0x0000_0080. LHU addr 0x2002 -> 0x0000_80FF.
- SB addr 0x3001, store_data 0x1234_56AB -> data_write, mbe 4'b0010, wdata 0xABAB_ABAB. SH addr 0x3002 -> mbe 4'b1100, wdata 0x56AB_56AB.
- LW addr 0x4002 with MISALIGN_TRAP_EN -> no data_read, misaligned pulse plus mem_done 1 cycle after acceptance. Without the macro -> read at 0x4000.
- rst driven low mid-REQ, then late data_resp -> data_read drops within the same cycle, no mem_done, FSM in IDLE after release.
- Back-to-back SW then LW, resp in the first REQ cycle each -> two mem_done pulses 3 cycles apart; stray data_resp in IDLE ignored.
